// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - elastic ID/EX pipeline register with skid buffer, load-use stall, flush and debug freeze
// Optional build macro: ID_EX_PERF_EN adds perf_bubbles / perf_flushes saturating counters.
module id_ex_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned CTRL_W = 24,
  parameter int unsigned RA_W   = 5
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              debug,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [RA_W-1:0]   in_rs1,
  input  logic [RA_W-1:0]   in_rs2,
  input  logic              in_rs1_use,
  input  logic              in_rs2_use,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_memread,
  input  logic              in_regwrite,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [RA_W-1:0]   out_rs1,
  output logic [RA_W-1:0]   out_rs2,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_memread,
  output logic              out_regwrite,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              hz
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_flushes
`endif
);

  localparam int unsigned PL_W = PC_W + 3 * RA_W + 2 + 3 * XLEN + CTRL_W;

  logic [PL_W-1:0] o_q, o_d, s_q, s_d, in_pl;
  logic            o_valid_q, o_valid_d, s_valid_q, s_valid_d;
  logic            accept;

  assign in_pl = {in_pc, in_rs1, in_rs2, in_rd, in_memread, in_regwrite,
                  in_rs1_data, in_rs2_data, in_imm, in_ctrl};
  assign {out_pc, out_rs1, out_rs2, out_rd, out_memread, out_regwrite,
          out_rs1_data, out_rs2_data, out_imm, out_ctrl} = o_q;
  assign out_valid = o_valid_q;

  // A load sitting in EX whose destination is read by the decoding instruction
  assign hz = o_valid_q & out_memread & (out_rd != '0) &
              ((in_rs1_use & (in_rs1 == out_rd)) | (in_rs2_use & (in_rs2 == out_rd)));

  // Readiness depends only on registered skid state, never on out_ready
  assign in_ready = ~Rst & ~debug & ~flush & ~s_valid_q & ~hz;
  assign accept   = in_valid & in_ready;

  // Next-state selection: debug freezes, flush empties, otherwise drain skid first
  always_comb begin
    o_d       = o_q;
    s_d       = s_q;
    o_valid_d = o_valid_q;
    s_valid_d = s_valid_q;
    if (debug) begin
      o_valid_d = o_valid_q;
    end else if (flush) begin
      o_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!o_valid_q || out_ready) begin
      if (s_valid_q) begin
        o_d       = s_q;
        o_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (accept) begin
        o_d       = in_pl;
        o_valid_d = 1'b1;
      end else begin
        o_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_d       = in_pl;
      s_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset clearing payload and valids
  always_ff @(posedge clk) begin
    if (Rst) begin
      o_q       <= '0;
      s_q       <= '0;
      o_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      o_q       <= o_d;
      s_q       <= s_d;
      o_valid_q <= o_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubbles_q, perf_flushes_q;

  // Saturating event counters, frozen while debug is high
  always_ff @(posedge clk) begin
    if (Rst) begin
      perf_bubbles_q <= '0;
      perf_flushes_q <= '0;
    end else if (!debug) begin
      if (hz && in_valid && perf_bubbles_q != '1)
        perf_bubbles_q <= perf_bubbles_q + 32'd1;
      if (flush && (o_valid_q || s_valid_q || in_valid) && perf_flushes_q != '1)
        perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - self-checking bench for id_ex_pipe with queue-based reference model
module tb_id_ex_pipe;

  typedef struct packed {
    logic [7:0]  pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_use;
    logic        rs2_use;
    logic [4:0]  rd;
    logic        memread;
    logic        regwrite;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [23:0] ctrl;
  } inst_t;

  logic clk = 1'b0;
  logic Rst, debug, flush, in_valid, out_ready;
  inst_t cur;

  logic        in_ready, out_valid, out_memread, out_regwrite, hz;
  logic [7:0]  out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_rs1_data, out_rs2_data, out_imm;
  logic [23:0] out_ctrl;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubbles, perf_flushes;
`endif

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .Rst(Rst), .debug(debug), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(cur.pc), .in_rs1(cur.rs1), .in_rs2(cur.rs2),
    .in_rs1_use(cur.rs1_use), .in_rs2_use(cur.rs2_use), .in_rd(cur.rd),
    .in_memread(cur.memread), .in_regwrite(cur.regwrite),
    .in_rs1_data(cur.rs1_data), .in_rs2_data(cur.rs2_data),
    .in_imm(cur.imm), .in_ctrl(cur.ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_memread(out_memread), .out_regwrite(out_regwrite),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_ctrl(out_ctrl),
    .hz(hz)
`ifdef ID_EX_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic inst_t mk(input logic [7:0] pc, input logic [4:0] rd,
                               input logic mr, input logic [4:0] rs1, input logic u1);
    inst_t t;
    t.pc = pc; t.rd = rd; t.memread = mr; t.rs1 = rs1; t.rs1_use = u1;
    t.rs2 = 5'd31; t.rs2_use = 1'b0; t.regwrite = 1'b1;
    t.rs1_data = {24'hA5A5A5, pc};
    t.rs2_data = {pc, 24'h5A5A5A};
    t.imm = {24'd0, pc} * 32'd3;
    t.ctrl = {16'h1234, pc};
    return t;
  endfunction

  // Reference model: ordered list of held instructions (head is what EX sees)
  inst_t mq[$];
  logic [31:0] m_bub = 0, m_fl = 0;
  bit m_acc;

  function automatic bit m_hz();
    if (mq.size() == 0) return 1'b0;
    return mq[0].memread && mq[0].rd != 0 &&
           ((cur.rs1_use && cur.rs1 == mq[0].rd) || (cur.rs2_use && cur.rs2 == mq[0].rd));
  endfunction

  function automatic bit m_ready();
    return !Rst && !debug && !flush && mq.size() < 2 && !m_hz();
  endfunction

  always @(posedge clk) begin
    m_acc = in_valid && m_ready();
    if (Rst) begin
      mq.delete(); m_bub = 0; m_fl = 0;
    end else if (!debug) begin
      if (m_hz() && in_valid && m_bub != 32'hFFFFFFFF) m_bub = m_bub + 1;
      if (flush && (mq.size() > 0 || in_valid) && m_fl != 32'hFFFFFFFF) m_fl = m_fl + 1;
      if (flush) mq.delete();
      else begin
        if (out_ready && mq.size() > 0) void'(mq.pop_front());
        if (m_acc) mq.push_back(cur);
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("m_out_valid", 192'(out_valid), 192'(mq.size() > 0));
      chk("m_in_ready", 192'(in_ready), 192'(m_ready()));
      chk("m_hz", 192'(hz), 192'(m_hz()));
      if (mq.size() > 0)
        chk("m_payload",
            192'({out_pc, out_rs1, out_rs2, out_rd, out_memread, out_regwrite,
                  out_rs1_data, out_rs2_data, out_imm, out_ctrl}),
            192'({mq[0].pc, mq[0].rs1, mq[0].rs2, mq[0].rd, mq[0].memread, mq[0].regwrite,
                  mq[0].rs1_data, mq[0].rs2_data, mq[0].imm, mq[0].ctrl}));
`ifdef ID_EX_PERF_EN
      chk("m_perf_bubbles", 192'(perf_bubbles), 192'(m_bub));
      chk("m_perf_flushes", 192'(perf_flushes), 192'(m_fl));
`endif
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1; debug = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cur = mk(8'h00, 5'd1, 1'b0, 5'd2, 1'b0);
    nxt();
    started = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 192'(out_valid), 192'(0));
    chk("rst_in_ready", 192'(in_ready), 192'(0));
    chk("rst_hz", 192'(hz), 192'(0));
    chk("rst_out_pc", 192'(out_pc), 192'(0));
    nxt();
    Rst = 1'b0;

    // Streaming: four ALU ops back to back
    for (int i = 0; i < 4; i++) begin
      cur = mk(8'(4 * i), 5'(i + 1), 1'b0, 5'd7, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      chk("stream_in_ready", 192'(in_ready), 192'(1));
      if (i > 0) begin
        chk("stream_out_valid", 192'(out_valid), 192'(1));
        chk("stream_out_pc", 192'(out_pc), 192'(4 * (i - 1)));
      end
      nxt();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_pc", 192'(out_pc), 192'(8'h0C));
    nxt();

    // Load-use: lw x5 followed by a reader of x5
    cur = mk(8'h10, 5'd5, 1'b1, 5'd0, 1'b0); in_valid = 1'b1;
    nxt();
    cur = mk(8'h14, 5'd6, 1'b0, 5'd5, 1'b1);
    @(negedge clk);
    chk("lu_hz", 192'(hz), 192'(1));
    chk("lu_in_ready", 192'(in_ready), 192'(0));
    nxt();
    @(negedge clk);
    chk("lu_bubble", 192'(out_valid), 192'(0));
    chk("lu_hz_gone", 192'(hz), 192'(0));
    nxt();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lu_add_pc", 192'(out_pc), 192'(8'h14));
    nxt();
    cur = mk(8'h18, 5'd0, 1'b1, 5'd0, 1'b0); in_valid = 1'b1;
    nxt();
    cur = mk(8'h1C, 5'd6, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    chk("lu_rd0_hz", 192'(hz), 192'(0));
    chk("lu_rd0_ready", 192'(in_ready), 192'(1));
    nxt();
    in_valid = 1'b0;
    nxt();

    // Backpressure: two offered while EX stalls
    out_ready = 1'b0;
    cur = mk(8'h20, 5'd1, 1'b0, 5'd0, 1'b0); in_valid = 1'b1;
    nxt();
    cur = mk(8'h24, 5'd2, 1'b0, 5'd0, 1'b0);
    nxt();
    cur = mk(8'h28, 5'd3, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk("bp_full_ready", 192'(in_ready), 192'(0));
    chk("bp_hold_pc", 192'(out_pc), 192'(8'h20));
    nxt();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_pc0", 192'(out_pc), 192'(8'h20));
    chk("bp_rel_ready", 192'(in_ready), 192'(0));
    nxt();
    @(negedge clk);
    chk("bp_rel_pc1", 192'(out_pc), 192'(8'h24));
    nxt();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_rel_pc2", 192'(out_pc), 192'(8'h28));
    nxt();

    // Flush with both registers occupied and a new instruction offered
    out_ready = 1'b0;
    cur = mk(8'h30, 5'd1, 1'b0, 5'd0, 1'b0); in_valid = 1'b1;
    nxt();
    cur = mk(8'h34, 5'd2, 1'b0, 5'd0, 1'b0);
    nxt();
    cur = mk(8'h38, 5'd3, 1'b0, 5'd0, 1'b0); flush = 1'b1;
    nxt();
    flush = 1'b0; out_ready = 1'b1;
    cur = mk(8'h3C, 5'd4, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk("fl_out_valid", 192'(out_valid), 192'(0));
    nxt();
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_first_pc", 192'(out_pc), 192'(8'h3C));
    nxt();

    // Debug freeze mid-stream with a flush pulse inside it
    cur = mk(8'h40, 5'd1, 1'b0, 5'd0, 1'b0); in_valid = 1'b1;
    nxt();
    cur = mk(8'h44, 5'd2, 1'b0, 5'd0, 1'b0);
    nxt();
    cur = mk(8'h48, 5'd3, 1'b0, 5'd0, 1'b0); debug = 1'b1;
    for (int i = 0; i < 5; i++) begin
      flush = (i == 2);
      @(negedge clk);
      chk("dbg_hold_pc", 192'(out_pc), 192'(8'h44));
      chk("dbg_hold_valid", 192'(out_valid), 192'(1));
      chk("dbg_in_ready", 192'(in_ready), 192'(0));
      nxt();
    end
    debug = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("dbg_resume_ready", 192'(in_ready), 192'(1));
    nxt();
    in_valid = 1'b0;
    @(negedge clk);
    chk("dbg_resume_pc", 192'(out_pc), 192'(8'h48));
    nxt();

    // Reset with both registers occupied
    out_ready = 1'b0;
    cur = mk(8'h50, 5'd1, 1'b0, 5'd0, 1'b0); in_valid = 1'b1;
    nxt();
    cur = mk(8'h54, 5'd2, 1'b0, 5'd0, 1'b0);
    nxt();
    in_valid = 1'b0; Rst = 1'b1;
    @(negedge clk);
    chk("mrst_ready", 192'(in_ready), 192'(0));
    chk("mrst_pre_valid", 192'(out_valid), 192'(1));
    nxt();
    @(negedge clk);
    chk("mrst_valid", 192'(out_valid), 192'(0));
    chk("mrst_payload", 192'({out_pc, out_rd, out_rs1_data, out_imm, out_ctrl}), 192'(0));
`ifdef ID_EX_PERF_EN
    chk("mrst_perf", 192'({perf_bubbles, perf_flushes}), 192'(0));
`endif
    nxt();
    Rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 192'(in_ready), 192'(1));
    chk("post_rst_valid", 192'(out_valid), 192'(0));
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
